// File: rtl/vc_crossbar_input_ctrl_pkg.sv
// Shared definitions for the crossbar input control stage.
//   NUM_PORTS   : crossbar radix (inputs == outputs)
//   QUEUE_DEPTH : entries per input queue
//   dest_e      : destination field encoding, value 3 is illegal
//   inc_mod3    : 2-bit increment that wraps 2 -> 0
package vc_crossbar_input_ctrl_pkg;

  localparam int unsigned NUM_PORTS   = 3;
  localparam int unsigned QUEUE_DEPTH = 2;

  typedef enum logic [1:0] {
    DEST_OUT0    = 2'd0,
    DEST_OUT1    = 2'd1,
    DEST_OUT2    = 2'd2,
    DEST_ILLEGAL = 2'd3
  } dest_e;

  function automatic logic [1:0] inc_mod3(input logic [1:0] idx);
    return (idx == 2'd2) ? 2'd0 : idx + 2'd1;
  endfunction

endpackage

// File: rtl/vc_rr_arb3.sv
// Three-request round-robin arbiter with a registered priority pointer.
//   i_clk, i_reset : clock, synchronous active-high reset (pointer -> 0)
//   i_reqs         : request vector, bit i = input i requests
//   i_en           : grant is consumed this cycle; advance the pointer past the winner
//   o_grant        : index of the winning request (0 when nothing requests)
//   o_any          : at least one request is present
module vc_rr_arb3
  import vc_crossbar_input_ctrl_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic [2:0] i_reqs,
  input  logic       i_en,
  output logic [1:0] o_grant,
  output logic       o_any
);

  logic [1:0] r_ptr;
  logic [1:0] w_c0;
  logic [1:0] w_c1;
  logic [1:0] w_c2;

  // Search order starts at the pointer and walks forward modulo 3.
  always_comb begin
    w_c0    = r_ptr;
    w_c1    = inc_mod3(r_ptr);
    w_c2    = inc_mod3(w_c1);
    o_grant = 2'd0;
    o_any   = 1'b0;
    if (i_reqs[w_c0]) begin
      o_grant = w_c0;
      o_any   = 1'b1;
    end else if (i_reqs[w_c1]) begin
      o_grant = w_c1;
      o_any   = 1'b1;
    end else if (i_reqs[w_c2]) begin
      o_grant = w_c2;
      o_any   = 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_ptr <= 2'd0;
    end else if (i_en && o_any) begin
      r_ptr <= inc_mod3(o_grant);
    end
  end

endmodule

// File: rtl/vc_crossbar_input_ctrl.sv
// Input-side control for a 3x3 crossbar: three 2-entry input queues, per-output
// round-robin arbitration, crossbar data/select drive and output handshakes.
//   clk, reset          : clock, synchronous active-high reset
//   inN_msg/dest/val    : input stream N (dest 0..2 routes, 3 is discarded)
//   inN_rdy             : queue N not full
//   xbar_inN            : head payload of queue N
//   selN                : index of the input granted to output N
//   outN_val / outN_rdy : handshake for crossbar output N
//   drop                : a dest==3 head was discarded this cycle
module vc_crossbar_input_ctrl
  import vc_crossbar_input_ctrl_pkg::*;
#(
  parameter int unsigned BIT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [BIT_WIDTH-1:0] in0_msg,
  input  logic [BIT_WIDTH-1:0] in1_msg,
  input  logic [BIT_WIDTH-1:0] in2_msg,
  input  logic [1:0]           in0_dest,
  input  logic [1:0]           in1_dest,
  input  logic [1:0]           in2_dest,
  input  logic                 in0_val,
  input  logic                 in1_val,
  input  logic                 in2_val,
  output logic                 in0_rdy,
  output logic                 in1_rdy,
  output logic                 in2_rdy,
  output logic [BIT_WIDTH-1:0] xbar_in0,
  output logic [BIT_WIDTH-1:0] xbar_in1,
  output logic [BIT_WIDTH-1:0] xbar_in2,
  output logic [1:0]           sel0,
  output logic [1:0]           sel1,
  output logic [1:0]           sel2,
  output logic                 out0_val,
  output logic                 out1_val,
  output logic                 out2_val,
  input  logic                 out0_rdy,
  input  logic                 out1_rdy,
  input  logic                 out2_rdy,
  output logic                 drop
);

  logic [BIT_WIDTH-1:0] w_in_msg   [NUM_PORTS];
  logic [1:0]           w_in_dest  [NUM_PORTS];
  logic [BIT_WIDTH-1:0] w_head_msg [NUM_PORTS];
  logic [1:0]           w_head_dest[NUM_PORTS];
  logic [NUM_PORTS-1:0] w_req      [NUM_PORTS];  // w_req[out][in]
  logic [1:0]           w_sel      [NUM_PORTS];
  logic [NUM_PORTS-1:0] w_in_val;
  logic [NUM_PORTS-1:0] w_in_rdy;
  logic [NUM_PORTS-1:0] w_out_rdy;
  logic [NUM_PORTS-1:0] w_out_val;
  logic [NUM_PORTS-1:0] w_fire;
  logic [NUM_PORTS-1:0] w_nonempty;
  logic [NUM_PORTS-1:0] w_illegal;
  logic [NUM_PORTS-1:0] w_deq;

  assign w_in_msg[0]  = in0_msg;
  assign w_in_msg[1]  = in1_msg;
  assign w_in_msg[2]  = in2_msg;
  assign w_in_dest[0] = in0_dest;
  assign w_in_dest[1] = in1_dest;
  assign w_in_dest[2] = in2_dest;
  assign w_in_val     = {in2_val, in1_val, in0_val};
  assign w_out_rdy    = {out2_rdy, out1_rdy, out0_rdy};

  for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_queue
    logic [BIT_WIDTH-1:0] r_msg [QUEUE_DEPTH];
    logic [1:0]           r_dest[QUEUE_DEPTH];
    logic                 r_wr_ptr;
    logic                 r_rd_ptr;
    logic [1:0]           r_cnt;
    logic                 w_enq;

    // Gating with reset keeps the queue invisible while reset is held.
    assign w_in_rdy[gi]    = !reset && (r_cnt != 2'(QUEUE_DEPTH));
    assign w_nonempty[gi]  = !reset && (r_cnt != 2'd0);
    assign w_enq           = w_in_val[gi] && w_in_rdy[gi];
    assign w_head_msg[gi]  = r_msg[r_rd_ptr];
    assign w_head_dest[gi] = r_dest[r_rd_ptr];
    assign w_illegal[gi]   = w_nonempty[gi] && (w_head_dest[gi] == DEST_ILLEGAL);

    always_ff @(posedge clk) begin
      if (reset) begin
        r_wr_ptr <= 1'b0;
        r_rd_ptr <= 1'b0;
        r_cnt    <= 2'd0;
      end else begin
        if (w_enq) begin
          r_msg[r_wr_ptr]  <= w_in_msg[gi];
          r_dest[r_wr_ptr] <= w_in_dest[gi];
          r_wr_ptr         <= !r_wr_ptr;
        end
        if (w_deq[gi]) begin
          r_rd_ptr <= !r_rd_ptr;
        end
        case ({w_enq, w_deq[gi]})
          2'b10:   r_cnt <= r_cnt + 2'd1;
          2'b01:   r_cnt <= r_cnt - 2'd1;
          default: ;
        endcase
      end
    end
  end

  // A head targets exactly one output, so requests are disjoint across outputs.
  always_comb begin
    for (int j = 0; j < NUM_PORTS; j++) begin
      w_req[j] = '0;
      for (int i = 0; i < NUM_PORTS; i++) begin
        w_req[j][i] = w_nonempty[i] && (w_head_dest[i] == 2'(j));
      end
    end
  end

  for (genvar gj = 0; gj < NUM_PORTS; gj++) begin : g_arb
    vc_rr_arb3 u_arb (
      .i_clk   (clk),
      .i_reset (reset),
      .i_reqs  (w_req[gj]),
      .i_en    (w_fire[gj]),
      .o_grant (w_sel[gj]),
      .o_any   (w_out_val[gj])
    );
    assign w_fire[gj] = w_out_val[gj] && w_out_rdy[gj];
  end

  // Illegal heads leave immediately; legal heads leave only when their output fires.
  always_comb begin
    w_deq = w_illegal;
    for (int j = 0; j < NUM_PORTS; j++) begin
      if (w_fire[j]) begin
        w_deq[w_sel[j]] = 1'b1;
      end
    end
  end

  assign in0_rdy  = w_in_rdy[0];
  assign in1_rdy  = w_in_rdy[1];
  assign in2_rdy  = w_in_rdy[2];
  assign xbar_in0 = reset ? '0 : w_head_msg[0];
  assign xbar_in1 = reset ? '0 : w_head_msg[1];
  assign xbar_in2 = reset ? '0 : w_head_msg[2];
  assign sel0     = w_sel[0];
  assign sel1     = w_sel[1];
  assign sel2     = w_sel[2];
  assign out0_val = w_out_val[0];
  assign out1_val = w_out_val[1];
  assign out2_val = w_out_val[2];
  assign drop     = |w_illegal;

endmodule

// File: tb/tb_vc_crossbar_input_ctrl.sv
// Directed self-checking bench for vc_crossbar_input_ctrl.
module tb_vc_crossbar_input_ctrl;

  logic        clk;
  logic        reset;
  logic [31:0] in0_msg, in1_msg, in2_msg;
  logic [1:0]  in0_dest, in1_dest, in2_dest;
  logic        in0_val, in1_val, in2_val;
  logic        in0_rdy, in1_rdy, in2_rdy;
  logic [31:0] xbar_in0, xbar_in1, xbar_in2;
  logic [1:0]  sel0, sel1, sel2;
  logic        out0_val, out1_val, out2_val;
  logic        out0_rdy, out1_rdy, out2_rdy;
  logic        drop;

  int n_checks;
  int n_bad;

  vc_crossbar_input_ctrl #(.BIT_WIDTH(32)) dut (
    .clk      (clk),
    .reset    (reset),
    .in0_msg  (in0_msg),
    .in1_msg  (in1_msg),
    .in2_msg  (in2_msg),
    .in0_dest (in0_dest),
    .in1_dest (in1_dest),
    .in2_dest (in2_dest),
    .in0_val  (in0_val),
    .in1_val  (in1_val),
    .in2_val  (in2_val),
    .in0_rdy  (in0_rdy),
    .in1_rdy  (in1_rdy),
    .in2_rdy  (in2_rdy),
    .xbar_in0 (xbar_in0),
    .xbar_in1 (xbar_in1),
    .xbar_in2 (xbar_in2),
    .sel0     (sel0),
    .sel1     (sel1),
    .sel2     (sel2),
    .out0_val (out0_val),
    .out1_val (out1_val),
    .out2_val (out2_val),
    .out0_rdy (out0_rdy),
    .out1_rdy (out1_rdy),
    .out2_rdy (out2_rdy),
    .drop     (drop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance past the next rising edge; inputs are then driven away from the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] xbar_at(input logic [1:0] idx);
    case (idx)
      2'd0:    return xbar_in0;
      2'd1:    return xbar_in1;
      default: return xbar_in2;
    endcase
  endfunction

  int          sent[3];
  int          got[3];
  logic [2:0]  rdy_snap;
  logic [1:0]  s;

  initial begin
    n_checks = 0;
    n_bad    = 0;
    reset    = 1'b1;
    in0_msg  = '0; in1_msg = '0; in2_msg = '0;
    in0_dest = '0; in1_dest = '0; in2_dest = '0;
    in0_val  = 1'b0; in1_val = 1'b0; in2_val = 1'b0;
    out0_rdy = 1'b0; out1_rdy = 1'b0; out2_rdy = 1'b0;
    tick();
    tick();

    // Reset state
    check("rst_in0_rdy", 32'(in0_rdy), 32'd0);
    check("rst_out_val", 32'({out2_val, out1_val, out0_val}), 32'd0);
    check("rst_sels", 32'({sel2, sel1, sel0}), 32'd0);
    check("rst_drop", 32'(drop), 32'd0);
    check("rst_xbar_in0", xbar_in0, 32'd0);

    reset = 1'b0;
    #1;
    check("post_rst_rdy", 32'({in2_rdy, in1_rdy, in0_rdy}), 32'h7);

    // Single message in0 -> out1
    in0_msg = 32'hA5; in0_dest = 2'd1; in0_val = 1'b1; out1_rdy = 1'b1;
    tick();
    in0_val = 1'b0;
    #1;
    check("t1_out1_val", 32'(out1_val), 32'd1);
    check("t1_sel1", 32'(sel1), 32'd0);
    check("t1_xbar_in0", xbar_in0, 32'hA5);
    check("t1_other_val", 32'({out2_val, out0_val}), 32'd0);
    check("t1_other_sel", 32'({sel2, sel0}), 32'd0);
    tick();
    #1;
    check("t1_drained", 32'(out1_val), 32'd0);

    // Three-way contention on out2
    for (int i = 0; i < 3; i++) begin
      sent[i] = 0;
      got[i]  = 0;
    end
    in0_dest = 2'd2; in1_dest = 2'd2; in2_dest = 2'd2;
    in0_val = 1'b1; in1_val = 1'b1; in2_val = 1'b1;
    out2_rdy = 1'b1;
    for (int k = 0; k < 10; k++) begin
      in0_msg = 32'h000 + 32'(sent[0]);
      in1_msg = 32'h100 + 32'(sent[1]);
      in2_msg = 32'h200 + 32'(sent[2]);
      #1;
      rdy_snap = {in2_rdy, in1_rdy, in0_rdy};
      if (k > 0) begin
        check("t2_out2_val", 32'(out2_val), 32'd1);
        check("t2_sel2", 32'(sel2), 32'((k - 1) % 3));
        s = sel2;
        check("t2_data", xbar_at(s), 32'(s) * 32'h100 + 32'(got[s]));
        got[s]++;
      end
      tick();
      for (int i = 0; i < 3; i++) begin
        if (rdy_snap[i]) sent[i]++;
      end
    end
    in0_val = 1'b0; in1_val = 1'b0; in2_val = 1'b0;
    for (int k = 0; k < 12; k++) begin
      #1;
      if (out2_val) begin
        s = sel2;
        check("t2_drain_data", xbar_at(s), 32'(s) * 32'h100 + 32'(got[s]));
        got[s]++;
      end
      tick();
    end
    for (int i = 0; i < 3; i++) begin
      check("t2_no_loss", 32'(got[i]), 32'(sent[i]));
    end

    // Backpressure on out1 with in1 sending 1,2,3
    out1_rdy = 1'b0; out2_rdy = 1'b0;
    in1_dest = 2'd1; in1_msg = 32'd1; in1_val = 1'b1;
    #1;
    check("t3_rdy_a", 32'(in1_rdy), 32'd1);
    tick();
    in1_msg = 32'd2;
    #1;
    check("t3_rdy_b", 32'(in1_rdy), 32'd1);
    check("t3_val_b", 32'(out1_val), 32'd1);
    check("t3_sel1", 32'(sel1), 32'd1);
    check("t3_head_b", xbar_in1, 32'd1);
    tick();
    in1_msg = 32'd3;
    #1;
    check("t3_full", 32'(in1_rdy), 32'd0);
    tick();
    #1;
    check("t3_still_full", 32'(in1_rdy), 32'd0);
    check("t3_stall_val", 32'(out1_val), 32'd1);
    check("t3_stall_head", xbar_in1, 32'd1);
    out1_rdy = 1'b1;
    #1;
    check("t3_out_1", xbar_in1, 32'd1);
    tick();
    #1;
    check("t3_rdy_after", 32'(in1_rdy), 32'd1);
    check("t3_out_2", xbar_in1, 32'd2);
    tick();
    in1_val = 1'b0;
    #1;
    check("t3_out_3", xbar_in1, 32'd3);
    check("t3_val_3", 32'(out1_val), 32'd1);
    tick();
    #1;
    check("t3_empty", 32'(out1_val), 32'd0);

    // Illegal destination on in2
    in2_msg = 32'h77; in2_dest = 2'd3; in2_val = 1'b1;
    tick();
    in2_val = 1'b0;
    #1;
    check("t4_drop", 32'(drop), 32'd1);
    check("t4_no_val", 32'({out2_val, out1_val, out0_val}), 32'd0);
    tick();
    #1;
    check("t4_drop_once", 32'(drop), 32'd0);
    check("t4_empty", 32'({out2_val, out1_val, out0_val}), 32'd0);

    // Parallel non-conflicting traffic
    out0_rdy = 1'b1; out1_rdy = 1'b1; out2_rdy = 1'b1;
    in0_msg = 32'h10; in0_dest = 2'd2; in0_val = 1'b1;
    in1_msg = 32'h11; in1_dest = 2'd0; in1_val = 1'b1;
    in2_msg = 32'h12; in2_dest = 2'd1; in2_val = 1'b1;
    tick();
    in0_val = 1'b0; in1_val = 1'b0; in2_val = 1'b0;
    #1;
    check("t5_vals", 32'({out2_val, out1_val, out0_val}), 32'h7);
    check("t5_sel2", 32'(sel2), 32'd0);
    check("t5_sel0", 32'(sel0), 32'd1);
    check("t5_sel1", 32'(sel1), 32'd2);
    tick();
    #1;
    check("t5_all_fired", 32'({out2_val, out1_val, out0_val}), 32'd0);

    // Reset with full queues under backpressure
    out0_rdy = 1'b0; out1_rdy = 1'b0; out2_rdy = 1'b0;
    in0_dest = 2'd0; in1_dest = 2'd0; in2_dest = 2'd0;
    in0_msg = 32'hB0; in1_msg = 32'hB1; in2_msg = 32'hB2;
    in0_val = 1'b1; in1_val = 1'b1; in2_val = 1'b1;
    tick();
    tick();
    in0_val = 1'b0; in1_val = 1'b0; in2_val = 1'b0;
    #1;
    check("t6_full", 32'({in2_rdy, in1_rdy, in0_rdy}), 32'd0);
    check("t6_pending", 32'(out0_val), 32'd1);
    reset = 1'b1;
    tick();
    #1;
    check("t6_rst_val", 32'({out2_val, out1_val, out0_val}), 32'd0);
    check("t6_rst_rdy", 32'({in2_rdy, in1_rdy, in0_rdy}), 32'd0);
    check("t6_rst_xbar", xbar_in0, 32'd0);
    reset = 1'b0;
    out0_rdy = 1'b1;
    #1;
    check("t6_rdy_back", 32'({in2_rdy, in1_rdy, in0_rdy}), 32'h7);
    check("t6_no_old_a", 32'(out0_val), 32'd0);
    tick();
    #1;
    check("t6_no_old_b", 32'({out2_val, out1_val, out0_val}), 32'd0);

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
